// File: rtl/divider_control_unit.sv
// divider_control_unit
//   Sequencing controller for the fixed-point divider datapath: loads operands,
//   pulses the datapath init, runs iterations until the counter carry-out,
//   and presents the quotient and error flags on a valid/ready handshake.
//   Optional build macro: DIV_SATURATE_EN saturates the result on
//   divide-by-zero / overflow (all ones) and forces 0 on timeout.
//   Without it, overflow returns the raw quotient and the other errors return 0.
module divider_control_unit #(
  parameter int WIDTH = 10,
  parameter int ITER  = 14,
  parameter int TMO   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             b_zero,
  input  logic             co_cnt,
  input  logic             ov,
  input  logic [WIDTH-1:0] q_in,
  output logic             ld_a,
  output logic             ld_b,
  output logic             dp_init,
  output logic             dp_run,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err_dvz,
  output logic             err_ovf,
  output logic             err_tmo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  localparam int              CNT_W    = $clog2(ITER + TMO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER + TMO - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_run_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_err_dvz;
  logic             r_err_ovf;
  logic             r_err_tmo;
  logic             r_ld;
  logic             r_dp_init;
  logic             r_dp_run;
  logic             r_busy;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_dvz_val;
  logic [WIDTH-1:0] w_ovf_val;
  logic             w_timeout;

  assign w_timeout = (r_run_cnt == CNT_LAST);

  // Fault result values: the only difference between the two builds.
  always_comb begin
`ifdef DIV_SATURATE_EN
    w_dvz_val = '1;
    w_ovf_val = '1;
`else
    w_dvz_val = '0;
    w_ovf_val = q_in;
`endif
  end

  // Next-state decode; RUN exits with priority ov > co_cnt > timeout.
  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_CHECK;
      S_CHECK: w_next_state = b_zero ? S_DONE : S_INIT;
      S_INIT:  w_next_state = S_RUN;
      S_RUN:   if (ov || co_cnt || w_timeout) w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ld        <= 1'b0;
      r_dp_init   <= 1'b0;
      r_dp_run    <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_state     <= w_next_state;
      r_ld        <= (w_next_state == S_LOAD);
      r_dp_init   <= (w_next_state == S_INIT);
      r_dp_run    <= (w_next_state == S_RUN);
      r_busy      <= (w_next_state != S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
    end
  end

  // RUN-cycle counter: cleared while in INIT, counts each RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_cnt <= '0;
    end else if (r_state == S_INIT) begin
      r_run_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  // Result and error capture on entry to DONE; held until the handshake completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result  <= '0;
      r_err_dvz <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      unique case (r_state)
        S_CHECK: begin
          if (b_zero) begin
            r_err_dvz <= 1'b1;
            r_result  <= w_dvz_val;
          end
        end
        S_RUN: begin
          if (ov) begin
            r_err_ovf <= 1'b1;
            r_result  <= w_ovf_val;
          end else if (co_cnt) begin
            r_result  <= q_in;
          end else if (w_timeout) begin
            r_err_tmo <= 1'b1;
            r_result  <= '0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_result  <= '0;
            r_err_dvz <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_tmo <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ld_a      = r_ld;
  assign ld_b      = r_ld;
  assign dp_init   = r_dp_init;
  assign dp_run    = r_dp_run;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err_dvz   = r_err_dvz;
  assign err_ovf   = r_err_ovf;
  assign err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_divider_control_unit.sv
// tb_divider_control_unit
//   Directed bench for divider_control_unit: normal division, divide-by-zero,
//   overflow, backpressure with ignored start, timeout and mid-run reset.
module tb_divider_control_unit;

  localparam int WIDTH = 10;

  // Control vector order: {ld_a, ld_b, dp_init, dp_run, busy, out_valid}
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_LOAD  = 6'b110010;
  localparam logic [5:0] C_CHECK = 6'b000010;
  localparam logic [5:0] C_INIT  = 6'b001010;
  localparam logic [5:0] C_RUN   = 6'b000110;
  localparam logic [5:0] C_DONE  = 6'b000011;

`ifdef DIV_SATURATE_EN
  localparam logic [WIDTH-1:0] EXP_DVZ = 10'h3FF;
  localparam logic [WIDTH-1:0] EXP_OVF = 10'h3FF;
`else
  localparam logic [WIDTH-1:0] EXP_DVZ = 10'h000;
  localparam logic [WIDTH-1:0] EXP_OVF = 10'h123;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             b_zero;
  logic             co_cnt;
  logic             ov;
  logic [WIDTH-1:0] q_in;
  logic             ld_a;
  logic             ld_b;
  logic             dp_init;
  logic             dp_run;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err_dvz;
  logic             err_ovf;
  logic             err_tmo;

  int n_chk;
  int n_err;

  divider_control_unit #(.WIDTH(WIDTH), .ITER(14), .TMO(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .b_zero    (b_zero),
    .co_cnt    (co_cnt),
    .ov        (ov),
    .q_in      (q_in),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .dp_init   (dp_init),
    .dp_run    (dp_run),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err_dvz   (err_dvz),
    .err_ovf   (err_ovf),
    .err_tmo   (err_tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] ctrl();
    return {ld_a, ld_b, dp_init, dp_run, busy, out_valid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles c0..c3: start, LOAD, CHECK (with divisor flag), then INIT unless b_zero.
  task automatic begin_op(input logic bz);
    start = 1'b1;
    step();
    chk("load_ctrl", ctrl(), C_LOAD);
    start = 1'b0;
    step();
    chk("check_ctrl", ctrl(), C_CHECK);
    b_zero = bz;
    step();
    b_zero = 1'b0;
  endtask

  // Full nominal division: co_cnt on the 14th RUN cycle, out_valid at c18.
  task automatic normal_run(input string tag);
    begin_op(1'b0);
    chk({tag, "_init"}, ctrl(), C_INIT);
    step();
    q_in = 10'h050;
    for (int k = 1; k <= 14; k++) begin
      if (ctrl() !== C_RUN) chk({tag, "_run"}, ctrl(), C_RUN);
      co_cnt = (k == 14);
      step();
    end
    co_cnt = 1'b0;
    chk({tag, "_valid"}, ctrl(), C_DONE);
    chk({tag, "_result"}, result, 10'h050);
    chk({tag, "_errs"}, {err_dvz, err_ovf, err_tmo}, 3'b000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, ctrl(), C_IDLE);
    chk({tag, "_clr"}, result, 10'h000);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b0;
    start     = 1'b0;
    b_zero    = 1'b0;
    co_cnt    = 1'b0;
    ov        = 1'b0;
    q_in      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", ctrl(), C_IDLE);
    chk("reset_result", result, 10'h000);
    chk("reset_errs", {err_dvz, err_ovf, err_tmo}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("idle_ctrl", ctrl(), C_IDLE);

    // 1: normal division
    normal_run("normal");

    // 2: divide-by-zero, out_valid at c3, datapath never initialised
    begin_op(1'b1);
    chk("dvz_valid", ctrl(), C_DONE);
    chk("dvz_errs", {err_dvz, err_ovf, err_tmo}, 3'b100);
    chk("dvz_result", result, EXP_DVZ);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("dvz_idle", ctrl(), C_IDLE);
    chk("dvz_clr", {err_dvz, err_ovf, err_tmo}, 3'b000);

    // 3: overflow and co_cnt together on RUN cycle 5; ov wins
    begin_op(1'b0);
    chk("ovf_init", ctrl(), C_INIT);
    step();
    for (int k = 1; k <= 5; k++) begin
      if (ctrl() !== C_RUN) chk("ovf_run", ctrl(), C_RUN);
      if (k == 5) begin
        ov     = 1'b1;
        co_cnt = 1'b1;
        q_in   = 10'h123;
      end
      step();
    end
    ov     = 1'b0;
    co_cnt = 1'b0;
    chk("ovf_valid", ctrl(), C_DONE);
    chk("ovf_errs", {err_dvz, err_ovf, err_tmo}, 3'b010);
    chk("ovf_result", result, EXP_OVF);

    // 4: backpressure, start pulses ignored, result held while q_in changes
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      q_in  = 10'(k * 37);
      step();
      if (ctrl() !== C_DONE) chk("bp_ctrl", ctrl(), C_DONE);
      if (result !== EXP_OVF) chk("bp_result", result, EXP_OVF);
      if ({err_dvz, err_ovf, err_tmo} !== 3'b010) chk("bp_errs", {err_dvz, err_ovf, err_tmo}, 3'b010);
    end
    chk("bp_hold_ctrl", ctrl(), C_DONE);
    chk("bp_hold_result", result, EXP_OVF);
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("bp_release_ctrl", ctrl(), C_IDLE);
    chk("bp_release_result", result, 10'h000);
    step();
    chk("bp_no_load", ctrl(), C_IDLE);

    // 5: timeout after 16 RUN cycles without co_cnt
    begin_op(1'b0);
    chk("tmo_init", ctrl(), C_INIT);
    step();
    q_in = 10'h2AA;
    for (int k = 1; k <= 16; k++) begin
      if (ctrl() !== C_RUN) chk("tmo_run", ctrl(), C_RUN);
      step();
    end
    chk("tmo_valid", ctrl(), C_DONE);
    chk("tmo_errs", {err_dvz, err_ovf, err_tmo}, 3'b001);
    chk("tmo_result", result, 10'h000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("tmo_idle", ctrl(), C_IDLE);

    // 6: asynchronous reset during RUN cycle 7, then a clean nominal run
    begin_op(1'b0);
    step();
    for (int k = 1; k < 7; k++) step();
    chk("rst_pre", ctrl(), C_RUN);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_ctrl", ctrl(), C_IDLE);
    chk("rst_async_result", result, 10'h000);
    chk("rst_async_errs", {err_dvz, err_ovf, err_tmo}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rst_idle", ctrl(), C_IDLE);
    normal_run("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
